// File: rtl/bp_update_sched.sv
// PHT access scheduler for the branch predictor: GHR, lookup/update arbitration, update FIFO.
// Optional gshare lookup indexing when BP_GSHARE_EN is defined.
module bp_update_sched #(
   parameter int REGSIZE    = 2,
   parameter int QDEPTH     = 4,
   parameter int STARVE_LIM = 3
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               lk_valid,
   input  logic [REGSIZE-1:0] lk_pc,
   output logic               lk_ready,
   output logic               pred_valid,
   output logic               pred_taken,
   output logic [REGSIZE-1:0] pred_idx,
   output logic [REGSIZE-1:0] pred_hist,
   input  logic               rs_valid,
   input  logic               rs_taken,
   input  logic               rs_mispred,
   input  logic [REGSIZE-1:0] rs_idx,
   input  logic [REGSIZE-1:0] rs_hist,
   output logic               rs_ready,
   output logic               pht_en,
   output logic               pht_pcbranch,
   output logic [REGSIZE-1:0] pht_addr,
   input  logic [1:0]         pht_count
);

   localparam int PW = $clog2(QDEPTH);
   localparam int SW = $clog2(STARVE_LIM + 1);
   localparam logic [SW-1:0] LIM = SW'(STARVE_LIM);
   localparam logic [PW:0]   FULL = (PW + 1)'(QDEPTH);

   typedef enum logic {
      S_ARB,
      S_FORCE
   } state_t;

   state_t             r_state;
   logic [REGSIZE-1:0] r_ghr;
   logic [SW-1:0]      r_starve;
   logic [PW-1:0]      r_wp;
   logic [PW-1:0]      r_rp;
   logic [PW:0]        r_cnt;
   logic [REGSIZE-1:0] r_q_idx [QDEPTH];
   logic               r_q_tkn [QDEPTH];
   logic               r_pred_valid;
   logic               r_pred_taken;
   logic [REGSIZE-1:0] r_pred_idx;
   logic [REGSIZE-1:0] r_pred_hist;

   logic               w_empty;
   logic               w_full;
   logic               w_grant;
   logic               w_pop;
   logic               w_push;
   logic               w_mis;
   logic [REGSIZE-1:0] w_lk_idx;
   logic [REGSIZE-1:0] w_ghr_nxt;
   logic [SW-1:0]      w_starve_nxt;
   logic               w_unused;

`ifdef BP_GSHARE_EN
   assign w_lk_idx = r_ghr ^ lk_pc;
   assign w_unused = pht_count[0];
`else
   assign w_lk_idx = r_ghr;
   assign w_unused = ^{pht_count[0], lk_pc};
`endif

   assign w_empty = (r_cnt == '0);
   assign w_full  = (r_cnt == FULL);
   assign w_grant = rstn & (r_state == S_ARB) & lk_valid;
   // FORCE only ever holds with a non-empty FIFO; the empty guard is defensive
   assign w_pop   = rstn & ~w_empty
                  & ((r_state == S_FORCE) | ~lk_valid);
   assign w_push  = rstn & rs_valid & ~w_full;
   assign w_mis   = w_push & rs_mispred;

   assign lk_ready     = w_grant;
   assign rs_ready     = rstn & ~w_full;
   assign pht_en       = w_pop;
   assign pht_pcbranch = w_pop & r_q_tkn[r_rp];
   assign pht_addr     = !rstn ? '0
                       : (w_pop ? r_q_idx[r_rp] : w_lk_idx);

   assign pred_valid = r_pred_valid;
   assign pred_taken = r_pred_taken;
   assign pred_idx   = r_pred_idx;
   assign pred_hist  = r_pred_hist;

   // Recovery wins over the speculative shift of a same-cycle lookup
   always_comb begin
      w_ghr_nxt = r_ghr;
      if (w_mis)
         w_ghr_nxt = {rs_hist[REGSIZE-2:0], rs_taken};
      else if (w_grant)
         w_ghr_nxt = {r_ghr[REGSIZE-2:0], pht_count[1]};
   end

   always_comb begin
      w_starve_nxt = r_starve;
      if (w_pop || w_empty)
         w_starve_nxt = '0;
      else if (w_grant && r_starve != LIM)
         w_starve_nxt = r_starve + SW'(1);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state      <= S_ARB;
         r_ghr        <= '0;
         r_starve     <= '0;
         r_pred_valid <= 1'b0;
         r_pred_taken <= 1'b0;
         r_pred_idx   <= '0;
         r_pred_hist  <= '0;
      end else begin
         r_ghr        <= w_ghr_nxt;
         r_starve     <= w_starve_nxt;
         r_pred_valid <= w_grant;
         if (w_grant) begin
            r_pred_taken <= pht_count[1];
            r_pred_idx   <= w_lk_idx;
            r_pred_hist  <= r_ghr;
         end
         case (r_state)
            S_ARB: begin
               if (w_starve_nxt == LIM)
                  r_state <= S_FORCE;
            end
            S_FORCE: r_state <= S_ARB;
            default: r_state <= S_ARB;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push)
            r_wp <= r_wp + PW'(1);
         if (w_pop)
            r_rp <= r_rp + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + (PW + 1)'(1);
            2'b01:   r_cnt <= r_cnt - (PW + 1)'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_q_idx[r_wp] <= rs_idx;
         r_q_tkn[r_wp] <= rs_taken;
      end
   end

endmodule

// File: tb/tb_bp_update_sched.sv
// Randomized scoreboard bench for bp_update_sched with a behavioural PHT.
module tb_bp_update_sched;

   localparam int RS = 2;
   localparam int QD = 4;
   localparam int SL = 3;

   logic          clk = 1'b0;
   logic          rstn;
   logic          lk_valid;
   logic [RS-1:0] lk_pc;
   logic          lk_ready;
   logic          pred_valid;
   logic          pred_taken;
   logic [RS-1:0] pred_idx;
   logic [RS-1:0] pred_hist;
   logic          rs_valid;
   logic          rs_taken;
   logic          rs_mispred;
   logic [RS-1:0] rs_idx;
   logic [RS-1:0] rs_hist;
   logic          rs_ready;
   logic          pht_en;
   logic          pht_pcbranch;
   logic [RS-1:0] pht_addr;
   logic [1:0]    pht_count;

   always #5 clk = ~clk;

   bp_update_sched #(
      .REGSIZE(RS), .QDEPTH(QD), .STARVE_LIM(SL)
   ) dut (
      .clk(clk), .rstn(rstn),
      .lk_valid(lk_valid), .lk_pc(lk_pc), .lk_ready(lk_ready),
      .pred_valid(pred_valid), .pred_taken(pred_taken),
      .pred_idx(pred_idx), .pred_hist(pred_hist),
      .rs_valid(rs_valid), .rs_taken(rs_taken),
      .rs_mispred(rs_mispred), .rs_idx(rs_idx),
      .rs_hist(rs_hist), .rs_ready(rs_ready),
      .pht_en(pht_en), .pht_pcbranch(pht_pcbranch),
      .pht_addr(pht_addr), .pht_count(pht_count)
   );

   // Behavioural PHT: saturating 2-bit counters, reset to weakly not-taken
   logic [1:0] pht [1 << RS];
   assign pht_count = pht[pht_addr];

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < (1 << RS); i++) pht[i] <= 2'b01;
      end else if (pht_en) begin
         if (pht_pcbranch && pht[pht_addr] != 2'b11)
            pht[pht_addr] <= pht[pht_addr] + 2'b01;
         else if (!pht_pcbranch && pht[pht_addr] != 2'b00)
            pht[pht_addr] <= pht[pht_addr] - 2'b01;
      end
   end

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(string nm, int act, int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t",
                  nm, act, exp, $time);
      end
   endtask

   typedef struct { int idx; int tkn; } upd_t;
   typedef struct { int tkn; int idx; int hist; } pred_t;

   upd_t  m_q[$];
   upd_t  exp_upd[$];
   pred_t exp_pred[$];
   int    m_ghr    = 0;
   int    m_starve = 0;
   bit    m_force  = 0;
   int    n_forced = 0;
   int    n_hold   = 0;
   int    n_ovr    = 0;

   // Reference model: evaluates each cycle from the arbitration rules
   always @(negedge clk) begin : model
      bit    full, empty, grant, pop;
      int    idx, tk, nghr;
      upd_t  u;
      pred_t p;
      if (!rstn) begin
         chk("rst_lk_ready", lk_ready, 0);
         chk("rst_rs_ready", rs_ready, 0);
         chk("rst_pht_en", pht_en, 0);
         chk("rst_pht_pcbranch", pht_pcbranch, 0);
         chk("rst_pht_addr", pht_addr, 0);
         chk("rst_pred_valid", pred_valid, 0);
         chk("rst_pred_taken", pred_taken, 0);
         chk("rst_pred_idx", pred_idx, 0);
         chk("rst_pred_hist", pred_hist, 0);
         m_q.delete();
         exp_upd.delete();
         exp_pred.delete();
         m_ghr    = 0;
         m_starve = 0;
         m_force  = 0;
      end else begin
         full  = (m_q.size() == QD);
         empty = (m_q.size() == 0);
         grant = lk_valid && !m_force;
         pop   = m_force || (!lk_valid && !empty);
         chk("lk_ready", lk_ready, int'(grant));
         chk("rs_ready", rs_ready, int'(!full));
         chk("pht_en", pht_en, int'(pop));
         if (m_force) n_forced++;
         nghr = m_ghr;
         if (grant) begin
`ifdef BP_GSHARE_EN
            idx = m_ghr ^ int'(lk_pc);
`else
            idx = m_ghr;
`endif
            chk("lookup_addr", int'(pht_addr), idx);
            tk = int'(pht[idx][1]);
            p.tkn  = tk;
            p.idx  = idx;
            p.hist = m_ghr;
            exp_pred.push_back(p);
            nghr = (m_ghr * 2 + tk) % (1 << RS);
         end
         if (pop) void'(m_q.pop_front());
         if (rs_valid && !full) begin
            u.idx = int'(rs_idx);
            u.tkn = int'(rs_taken);
            m_q.push_back(u);
            exp_upd.push_back(u);
            if (rs_mispred) begin
               nghr = (int'(rs_hist) * 2 + int'(rs_taken))
                    % (1 << RS);
               if (grant) n_ovr++;
            end
         end else if (rs_valid) begin
            n_hold++;
         end
         if (pop || empty)
            m_starve = 0;
         else if (grant && m_starve < SL)
            m_starve++;
         m_force = !m_force && (m_starve == SL);
         m_ghr   = nghr;
      end
   end

   // Monitor: consumes expectations whenever the DUT presents an output
   always @(negedge clk) begin : monitor
      pred_t p;
      upd_t  u;
      if (rstn) begin
         if (pred_valid) begin
            if (exp_pred.size() == 0) begin
               chk("pred_unexpected", 1, 0);
            end else begin
               p = exp_pred.pop_front();
               chk("pred_taken", int'(pred_taken), p.tkn);
               chk("pred_idx", int'(pred_idx), p.idx);
               chk("pred_hist", int'(pred_hist), p.hist);
            end
         end
         if (pht_en) begin
            if (exp_upd.size() == 0) begin
               chk("upd_unexpected", 1, 0);
            end else begin
               u = exp_upd.pop_front();
               chk("upd_addr", int'(pht_addr), u.idx);
               chk("upd_dir", int'(pht_pcbranch), u.tkn);
            end
         end
      end
   end

   task automatic run(int n, int lkp, int rsp, int misp);
      bit acc;
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         acc = rs_valid && rs_ready;
         @(posedge clk);
         #1;
         lk_valid = ($urandom_range(99) < lkp);
         lk_pc    = RS'($urandom);
         if (!rs_valid || acc) begin
            rs_valid   = ($urandom_range(99) < rsp);
            rs_taken   = 1'($urandom);
            rs_mispred = ($urandom_range(99) < misp);
            rs_idx     = RS'($urandom);
            rs_hist    = RS'($urandom);
         end
      end
   endtask

   task automatic do_reset(int cyc);
      @(posedge clk);
      #1;
      rstn     = 1'b0;
      lk_valid = 1'b0;
      rs_valid = 1'b0;
      repeat (cyc) @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   initial begin
      rstn       = 1'b1;
      lk_valid   = 1'b0;
      lk_pc      = '0;
      rs_valid   = 1'b0;
      rs_taken   = 1'b0;
      rs_mispred = 1'b0;
      rs_idx     = '0;
      rs_hist    = '0;
      #1 rstn = 1'b0;
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
      run(10, 100, 0, 0);
      run(40, 0, 100, 20);
      run(300, 100, 60, 30);
      run(300, 70, 50, 30);
      do_reset(2);
      run(200, 50, 50, 50);
      run(200, 100, 80, 40);
      run(30, 0, 0, 0);
      @(negedge clk);
      #1;
      chk("pred_q_drained", exp_pred.size(), 0);
      chk("upd_q_drained", exp_upd.size(), 0);
      chk("saw_forced_update", int'(n_forced > 0), 1);
      chk("saw_full_hold", int'(n_hold > 0), 1);
      chk("saw_mispred_override", int'(n_ovr > 0), 1);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
